// File: rtl/sp_stream_fifo_pkg.sv
// Shared constants and helpers for the single-port-RAM stream FIFO.
package sp_stream_fifo_pkg;

  // Number of prefetch entries sitting in front of the RAM.
  localparam int PF_DEPTH = 2;

  // Kind of RAM access performed in a given cycle.
  typedef enum logic [1:0] {
    RAM_IDLE  = 2'd0,
    RAM_WRITE = 2'd1,
    RAM_READ  = 2'd2
  } ram_op_e;

  // RAM depth from its address width.
  function automatic int ram_depth(input int aw);
    return 1 << aw;
  endfunction

  // Width of the occupancy counter: holds 0 .. DEPTH+PF_DEPTH.
  function automatic int count_width(input int aw);
    return aw + 2;
  endfunction

endpackage

// File: rtl/sp_stream_fifo_ram.sv
// Single-port RAM with registered read data; one access per cycle.
module sp_ram #(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          ce_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  // Write on ce&we, otherwise a read whose data is valid the next cycle.
  always_ff @(posedge clk) begin
    if (ce_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      else      rdata_o       <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/sp_stream_fifo.sv
// Valid/ready FIFO over one single-port RAM with a 2-entry prefetch
// buffer that is bypass-filled while the RAM and read pipe are empty.
module sp_stream_fifo
  import sp_stream_fifo_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW+1:0] count
);

  localparam int            DEPTH    = ram_depth(AW);
  localparam int            CW       = count_width(AW);
  localparam logic [AW:0]   RAM_FULL = (AW+1)'(DEPTH);
  localparam logic [1:0]    PF_FULL  = 2'(PF_DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   ram_cnt_q, ram_cnt_d;
  logic          rd_inflight_q, rd_inflight_d;
  logic [1:0]    pf_cnt_q, pf_cnt_d;
  logic [DW-1:0] pf0_q, pf0_d, pf1_q, pf1_d;
  logic [CW-1:0] count_q, count_d;

  logic          bypass, rd_req, urgent, push, pop, fill;
  logic [DW-1:0] fill_data, ram_rdata;
  ram_op_e       ram_op;

  // Arbitration depends on state only, so in_ready never waits on in_valid.
  always_comb begin
    bypass   = (ram_cnt_q == '0) && !rd_inflight_q && (pf_cnt_q < PF_FULL);
    rd_req   = (ram_cnt_q != '0) && ((pf_cnt_q + {1'b0, rd_inflight_q}) < PF_FULL);
    urgent   = rd_req && (pf_cnt_q == 2'd0) && !rd_inflight_q;
    in_ready = rst_n && (bypass || (!urgent && (ram_cnt_q < RAM_FULL)));
    push     = in_valid && in_ready;
    pop      = out_valid && out_ready;
    ram_op   = RAM_IDLE;
    if (!bypass) begin
      if (urgent)      ram_op = RAM_READ;
      else if (push)   ram_op = RAM_WRITE;
      else if (rd_req) ram_op = RAM_READ;
    end
    // A bypass push and a read return are mutually exclusive (bypass needs no read in flight).
    fill      = rd_inflight_q || (bypass && push);
    fill_data = rd_inflight_q ? ram_rdata : in_data;
  end

  // Next state for pointers, RAM occupancy, prefetch buffer and total count.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    ram_cnt_d     = ram_cnt_q;
    rd_inflight_d = (ram_op == RAM_READ);
    if (ram_op == RAM_WRITE) begin
      wr_ptr_d  = wr_ptr_q + 1'b1;
      ram_cnt_d = ram_cnt_q + 1'b1;
    end else if (ram_op == RAM_READ) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      ram_cnt_d = ram_cnt_q - 1'b1;
    end
    pf0_d    = pf0_q;
    pf1_d    = pf1_q;
    pf_cnt_d = pf_cnt_q;
    if (pop) begin
      pf0_d    = pf1_q;
      pf_cnt_d = pf_cnt_q - 2'd1;
    end
    if (fill) begin
      if (pf_cnt_d == 2'd0) pf0_d = fill_data;
      else                  pf1_d = fill_data;
      pf_cnt_d = pf_cnt_d + 2'd1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // State registers; reset also clears the visible output word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ram_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
      pf_cnt_q      <= 2'd0;
      pf0_q         <= '0;
      pf1_q         <= '0;
      count_q       <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ram_cnt_q     <= ram_cnt_d;
      rd_inflight_q <= rd_inflight_d;
      pf_cnt_q      <= pf_cnt_d;
      pf0_q         <= pf0_d;
      pf1_q         <= pf1_d;
      count_q       <= count_d;
    end
  end

  assign out_valid = (pf_cnt_q != 2'd0);
  assign out_data  = pf0_q;
  assign count     = count_q;

  sp_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk     (clk),
    .ce_i    (ram_op != RAM_IDLE),
    .we_i    (ram_op == RAM_WRITE),
    .addr_i  ((ram_op == RAM_WRITE) ? wr_ptr_q : rd_ptr_q),
    .wdata_i (in_data),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_sp_stream_fifo.sv
// Bench for sp_stream_fifo (AW=2): directed scenarios plus random traffic,
// with a queue-based reference holding every word the FIFO should contain.
module tb_sp_stream_fifo;

  localparam int DW  = 16;
  localparam int AW  = 2;
  localparam int CAP = (1 << AW) + 2;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [AW+1:0] count;

  sp_stream_fifo #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] model_q [$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            starve = 0;
  logic          last_rdy, last_pop;
  logic [DW-1:0] last_pop_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive, sample handshakes, clock, update the model, check.
  task automatic step(input logic rst_v, input logic iv, input logic [DW-1:0] d, input logic ordy);
    logic push, pop;
    rst_n     = rst_v;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    last_rdy      = in_ready;
    push          = iv & in_ready;
    pop           = out_valid & ordy;
    last_pop      = pop;
    last_pop_data = out_data;
    if (!rst_v) chk("ready_in_reset", in_ready, 0);
    else begin
      if (model_q.size() == 0)   chk("ready_when_empty", in_ready, 1);
      if (model_q.size() == CAP) chk("ready_when_full", in_ready, 0);
    end
    @(posedge clk);
    #1;
    if (!rst_v) model_q.delete();
    else begin
      if (pop)  void'(model_q.pop_front());
      if (push) model_q.push_back(d);
    end
    chk("count", count, model_q.size());
    if (model_q.size() == 0) chk("out_valid_empty", out_valid, 0);
    else if (out_valid) chk("out_data_head", out_data, model_q[0]);
    if (model_q.size() != 0 && !out_valid) starve++;
    else starve = 0;
    if (starve > 3) chk("out_valid_latency", out_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nxt, exp_v;
    logic [DW-1:0] d;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("reset_count", count, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);

    // Basic bypass: first two words go straight to the prefetch buffer.
    step(1, 1, 16'h0001, 0);
    chk("bypass_lat_valid", out_valid, 1);
    chk("bypass_lat_data", out_data, 16'h0001);
    step(1, 1, 16'h0002, 0);
    step(1, 1, 16'h0003, 0);
    chk("basic_count", count, 3);
    chk("basic_valid", out_valid, 1);
    chk("basic_data", out_data, 16'h0001);

    // Urgent read: drain the prefetch while pushes keep the RAM busy.
    step(1, 1, 16'h0004, 1);
    step(1, 1, 16'h0005, 1);
    step(1, 1, 16'h0006, 0);
    chk("urgent_ready", last_rdy, 0);
    chk("urgent_valid_c1", out_valid, 0);
    step(1, 1, 16'h0006, 0);
    chk("resume_ready", last_rdy, 1);
    chk("urgent_valid_c2", out_valid, 1);
    chk("urgent_data", out_data, 16'h0003);

    // Fill from empty with the consumer stalled.
    step(0, 0, 0, 0);
    nxt = 1;
    for (int n = 0; n < 12; n++) begin
      step(1, 1, 16'(nxt), 0);
      if (!last_rdy) break;
      nxt++;
    end
    chk("fill_accepted", nxt - 1, 6);
    chk("fill_count", count, 6);
    for (int n = 0; n < 3; n++) begin
      step(1, 1, 16'h00ff, 0);
      chk("full_ready", last_rdy, 0);
    end

    // Drain: words come out in push order.
    exp_v = 1;
    for (int n = 0; n < 24 && model_q.size() != 0; n++) begin
      step(1, 0, 0, 1);
      if (last_pop) begin
        chk("drain_order", last_pop_data, exp_v);
        exp_v++;
      end
    end
    chk("drain_total", exp_v - 1, 6);
    chk("drain_valid", out_valid, 0);
    chk("drain_count", count, 0);
    chk("drain_ready", in_ready, 1);

    // Streaming: full rate through the bypass path.
    step(0, 0, 0, 0);
    for (int n = 0; n < 100; n++) begin
      d = DW'($urandom);
      step(1, 1, d, 1);
      chk("stream_ready", last_rdy, 1);
      chk("stream_count_le2", 32'(count <= 2), 1);
    end

    // Random producer and consumer stalls.
    for (int n = 0; n < 400; n++) begin
      d = DW'($urandom);
      step(1, 1'($urandom_range(0, 1)), d, ($urandom_range(0, 2) != 0));
    end
    for (int n = 0; n < 30 && model_q.size() != 0; n++) step(1, 0, 0, 1);
    chk("random_drained", count, 0);
    chk("random_model_empty", model_q.size(), 0);

    // Reset in the middle of operation.
    for (int n = 0; n < 5; n++) step(1, 1, 16'(16'h0100 + n), 0);
    chk("midrst_pre_count", count, 5);
    step(0, 1, 16'h0dea, 1);
    chk("midrst_count", count, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    step(1, 1, 16'hbeef, 0);
    chk("midrst_bypass_valid", out_valid, 1);
    chk("midrst_bypass_data", out_data, 16'hbeef);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
